// File: rtl/hold_toggle_bank_if.sv
// hold_toggle_bank_if: button/enable inputs and toggle outputs of a hold-to-toggle bank
interface hold_toggle_bank_if #(parameter int CHANNELS = 2);
  logic [CHANNELS-1:0] btn;
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] state;
  logic [CHANNELS-1:0] toggle_pulse;
  logic [CHANNELS-1:0] holding;
  modport master (output btn, en, input state, toggle_pulse, holding);
  modport slave (input btn, en, output state, toggle_pulse, holding);
endinterface

// File: rtl/hold_toggle_bank.sv
// hold_toggle_bank: per-channel hold-to-toggle latches with optional auto-repeat and exclusive press
module hold_toggle_bank #(
  parameter int CHANNELS = 2,
  parameter int CNT_W = 26,
  parameter int HOLD_CYCLES = 33554432,
  parameter int REPEAT_CYCLES = 0,
  parameter bit EXCLUSIVE = 1'b0,
  parameter bit INIT_STATE = 1'b1
) (
  input logic clk,
  input logic rst,
  hold_toggle_bank_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COUNTING, LOCKED} fsm_t;
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_M1 = CNT_W'(REPEAT_CYCLES - 1);
  logic [CHANNELS-1:0] s1, sbtn;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      sbtn <= '0;
    end else begin
      s1 <= bus.btn;
      sbtn <= s1;
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    fsm_t fsm, fsm_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CHANNELS-1:0] others;
    logic pressed, flip, st, pl, hd;
    assign others = sbtn & ~(CHANNELS'(1) << i);
    assign pressed = sbtn[i] & bus.en[i] & (!EXCLUSIVE || others == '0);
    always_ff @(posedge clk) begin
      if (rst) begin
        fsm <= IDLE;
        cnt <= '0;
        st <= INIT_STATE;
        pl <= 1'b0;
      end else begin
        fsm <= fsm_n;
        cnt <= cnt_n;
        st <= st ^ flip;
        pl <= flip;
      end
    end
    // Terminal counts are compared before incrementing, so cnt never wraps.
    always_comb begin
      fsm_n = fsm;
      cnt_n = cnt;
      flip = 1'b0;
      case (fsm)
        IDLE: begin
          fsm_n = pressed ? COUNTING : IDLE;
          cnt_n = pressed ? CNT_W'(1) : '0;
        end
        COUNTING: begin
          flip = pressed && cnt == HOLD_M1;
          fsm_n = !pressed ? IDLE : flip ? LOCKED : COUNTING;
          cnt_n = (!pressed || flip) ? '0 : cnt + CNT_W'(1);
        end
        LOCKED: begin
          flip = pressed && REPEAT_CYCLES != 0 && cnt == REP_M1;
          fsm_n = pressed ? LOCKED : IDLE;
          cnt_n = (!pressed || flip || REPEAT_CYCLES == 0) ? '0 : cnt + CNT_W'(1);
        end
        default: begin
          fsm_n = IDLE;
          cnt_n = '0;
        end
      endcase
    end
    always_comb hd = fsm == COUNTING;
    assign bus.state[i] = st;
    assign bus.toggle_pulse[i] = pl;
    assign bus.holding[i] = hd;
  end
endmodule

// File: tb/tb_hold_toggle_bank.sv
// tb_hold_toggle_bank: table-driven check of three bank configurations against cycle-exact expectations
module tb_hold_toggle_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] btn = 2'b00;
  logic [1:0] en = 2'b11;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hold_toggle_bank_if #(.CHANNELS(2)) ia ();
  hold_toggle_bank_if #(.CHANNELS(2)) ir ();
  hold_toggle_bank_if #(.CHANNELS(2)) ix ();
  assign ia.btn = btn;
  assign ia.en = en;
  assign ir.btn = btn;
  assign ir.en = en;
  assign ix.btn = btn;
  assign ix.en = en;
  hold_toggle_bank #(.CHANNELS(2), .CNT_W(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(0), .EXCLUSIVE(1'b0), .INIT_STATE(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  hold_toggle_bank #(.CHANNELS(2), .CNT_W(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .EXCLUSIVE(1'b0), .INIT_STATE(1'b1))
    dut_r (.clk(clk), .rst(rst), .bus(ir));
  hold_toggle_bank #(.CHANNELS(2), .CNT_W(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(0), .EXCLUSIVE(1'b1), .INIT_STATE(1'b1))
    dut_x (.clk(clk), .rst(rst), .bus(ix));
  typedef struct {
    int sel;
    logic [1:0] st, pl, hd;
  } exp_t;
  typedef struct {
    logic rst;
    logic [1:0] btn, en;
    int n, sel;
    logic [1:0] st, pl, hd;
  } seg_t;
  exp_t sb[$];
  seg_t tbl[$];
  // sel: 0 = plain, 1 = auto-repeat, 2 = exclusive; -1 = outputs not checked
  task automatic cyc(input logic r, input logic [1:0] b, input logic [1:0] e, input int sel,
                     input logic [1:0] st, input logic [1:0] pl, input logic [1:0] hd);
    @(posedge clk);
    #1;
    rst = r;
    btn = b;
    en = e;
    if (sel >= 0) sb.push_back('{sel, st, pl, hd});
  endtask
  task automatic add(input logic r, input logic [1:0] b, input logic [1:0] e, input int n, input int sel,
                     input logic [1:0] st, input logic [1:0] pl, input logic [1:0] hd);
    tbl.push_back('{r, b, e, n, sel, st, pl, hd});
  endtask
  always @(negedge clk) begin
    exp_t x;
    logic [5:0] got;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      got = x.sel == 0 ? {ia.state, ia.toggle_pulse, ia.holding} :
            x.sel == 1 ? {ir.state, ir.toggle_pulse, ir.holding} : {ix.state, ix.toggle_pulse, ix.holding};
      n_run++;
      if (got !== {x.st, x.pl, x.hd}) begin
        n_fail++;
        $display("FAIL dut%0d t=%0t state/pulse/holding got %b/%b/%b want %b/%b/%b",
                 x.sel, $time, got[5:4], got[3:2], got[1:0], x.st, x.pl, x.hd);
      end
    end
  end
  initial begin
    @(posedge clk);
    #1;
    n_run++;
    if ({ia.state, ia.toggle_pulse, ia.holding, ir.state, ir.toggle_pulse, ir.holding,
         ix.state, ix.toggle_pulse, ix.holding} !== {3{6'b110000}}) begin
      n_fail++;
      $display("FAIL reset state t=%0t a=%b/%b/%b r=%b/%b/%b x=%b/%b/%b", $time,
               ia.state, ia.toggle_pulse, ia.holding, ir.state, ir.toggle_pulse, ir.holding,
               ix.state, ix.toggle_pulse, ix.holding);
    end
    // reset state of all three configurations
    add(1, 2'b00, 2'b11, 1, -1, 2'b11, 2'b00, 2'b00);
    add(1, 2'b00, 2'b11, 1, 0, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 1, 0, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 1, 1, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 1, 2, 2'b11, 2'b00, 2'b00);
    // long hold toggles once, second hold toggles back
    add(0, 2'b01, 2'b11, 3, 0, 2'b11, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 7, 0, 2'b11, 2'b00, 2'b01);
    add(0, 2'b01, 2'b11, 1, 0, 2'b10, 2'b01, 2'b00);
    add(0, 2'b01, 2'b11, 9, 0, 2'b10, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 4, 0, 2'b10, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 3, 0, 2'b10, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 7, 0, 2'b10, 2'b00, 2'b01);
    add(0, 2'b01, 2'b11, 1, 0, 2'b11, 2'b01, 2'b00);
    add(0, 2'b01, 2'b11, 9, 0, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 4, 0, 2'b11, 2'b00, 2'b00);
    // short press aborts, next press counts from zero
    add(0, 2'b01, 2'b11, 3, 0, 2'b11, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 2, 0, 2'b11, 2'b00, 2'b01);
    add(0, 2'b00, 2'b11, 3, 0, 2'b11, 2'b00, 2'b01);
    add(0, 2'b00, 2'b11, 2, 0, 2'b11, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 3, 0, 2'b11, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 7, 0, 2'b11, 2'b00, 2'b01);
    add(0, 2'b01, 2'b11, 1, 0, 2'b10, 2'b01, 2'b00);
    add(0, 2'b01, 2'b11, 1, 0, 2'b10, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 4, 0, 2'b10, 2'b00, 2'b00);
    // enable drop acts as release, count restarts when enable returns
    add(0, 2'b01, 2'b11, 3, 0, 2'b10, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 2, 0, 2'b10, 2'b00, 2'b01);
    add(0, 2'b01, 2'b00, 1, 0, 2'b10, 2'b00, 2'b01);
    add(0, 2'b01, 2'b00, 2, 0, 2'b10, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 1, 0, 2'b10, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 7, 0, 2'b10, 2'b00, 2'b01);
    add(0, 2'b01, 2'b11, 1, 0, 2'b11, 2'b01, 2'b00);
    add(0, 2'b00, 2'b11, 4, 0, 2'b11, 2'b00, 2'b00);
    // both channels flip in the same cycle
    add(0, 2'b11, 2'b11, 3, 0, 2'b11, 2'b00, 2'b00);
    add(0, 2'b11, 2'b11, 7, 0, 2'b11, 2'b00, 2'b11);
    add(0, 2'b11, 2'b11, 1, 0, 2'b00, 2'b11, 2'b00);
    add(0, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 4, 0, 2'b00, 2'b00, 2'b00);
    // exclusive mode
    add(1, 2'b00, 2'b11, 2, -1, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 1, 2, 2'b11, 2'b00, 2'b00);
    add(0, 2'b11, 2'b11, 20, 2, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 4, 2, 2'b11, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 3, 2, 2'b11, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 1, 2, 2'b11, 2'b00, 2'b01);
    add(0, 2'b11, 2'b11, 3, 2, 2'b11, 2'b00, 2'b01);
    add(0, 2'b11, 2'b11, 7, 2, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 4, 2, 2'b11, 2'b00, 2'b00);
    add(0, 2'b10, 2'b11, 3, 2, 2'b11, 2'b00, 2'b00);
    add(0, 2'b10, 2'b11, 7, 2, 2'b11, 2'b00, 2'b10);
    add(0, 2'b10, 2'b11, 1, 2, 2'b01, 2'b10, 2'b00);
    add(0, 2'b10, 2'b11, 1, 2, 2'b01, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 4, 2, 2'b01, 2'b00, 2'b00);
    // auto-repeat: flips at 10, 14, 18, 22
    add(1, 2'b00, 2'b11, 2, -1, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 1, 1, 2'b11, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 3, 1, 2'b11, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 7, 1, 2'b11, 2'b00, 2'b01);
    add(0, 2'b01, 2'b11, 1, 1, 2'b10, 2'b01, 2'b00);
    add(0, 2'b01, 2'b11, 3, 1, 2'b10, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 1, 1, 2'b11, 2'b01, 2'b00);
    add(0, 2'b01, 2'b11, 3, 1, 2'b11, 2'b00, 2'b00);
    add(0, 2'b01, 2'b11, 1, 1, 2'b10, 2'b01, 2'b00);
    add(0, 2'b01, 2'b11, 1, 1, 2'b10, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 2, 1, 2'b10, 2'b00, 2'b00);
    add(0, 2'b00, 2'b11, 1, 1, 2'b11, 2'b01, 2'b00);
    add(0, 2'b00, 2'b11, 4, 1, 2'b11, 2'b00, 2'b00);
    foreach (tbl[k])
      for (int j = 0; j < tbl[k].n; j++)
        cyc(tbl[k].rst, tbl[k].btn, tbl[k].en, tbl[k].sel, tbl[k].st, tbl[k].pl, tbl[k].hd);
    // reset pulsed mid-hold: counting restarts after the synchroniser refills
    cyc(1, 2'b00, 2'b11, -1, 2'b11, 2'b00, 2'b00);
    cyc(1, 2'b00, 2'b11, -1, 2'b11, 2'b00, 2'b00);
    cyc(0, 2'b00, 2'b11, 0, 2'b11, 2'b00, 2'b00);
    for (int c = 0; c < 35; c++)
      cyc(c == 6, c <= 30 ? 2'b01 : 2'b00, 2'b11, 0,
          c >= 17 ? 2'b10 : 2'b11,
          c == 17 ? 2'b01 : 2'b00,
          ((c >= 3 && c <= 6) || (c >= 10 && c <= 16)) ? 2'b01 : 2'b00);
    @(negedge clk);
    #1;
    n_run++;
    if ({ia.state, ia.toggle_pulse, ia.holding} !== 6'b100000) begin
      n_fail++;
      $display("FAIL expired wait t=%0t state/pulse/holding got %b/%b/%b want 10/00/00",
               $time, ia.state, ia.toggle_pulse, ia.holding);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
